// File: rtl/id_ex_decode_pkg.sv
// Shared RV32I decode constants: opcodes, funct3 codes, ALU control encodings
// and the registered ID/EX entry layout.
package id_ex_decode_pkg;

  // 7-bit major opcodes
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // funct3 codes
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_CSRRW   = 3'b001;
  localparam logic [2:0] F3_CSRRWI  = 3'b101;

  // funct7 codes for shifts
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // 4-bit ALU control encodings
  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_OR     = 4'd6;
  localparam logic [3:0] ALU_AND    = 4'd7;
  localparam logic [3:0] ALU_SRL    = 4'd8;
  localparam logic [3:0] ALU_SRA    = 4'd9;
  localparam logic [3:0] ALU_PASS_A = 4'd11;
  localparam logic [3:0] ALU_PASS_B = 4'd12;

  // One registered ID/EX entry
  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [3:0]  alu_ctr;
    logic        a_sel;
    logic        b_sel;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_wen;
    logic        mem_ren;
    logic        mem_wen;
    logic        br;
    logic        jmp;
    logic        csr_wen;
    logic        illegal;
  } ex_entry_t;

  // Bubble: everything cleared except the reported instruction word
  function automatic ex_entry_t bubble_entry(input logic [31:0] nop);
    ex_entry_t e;
    e      = '0;
    e.inst = nop;
    return e;
  endfunction

  // funct3 -> ALU op for register/immediate arithmetic; alt selects sub/sra
  function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:     op = ALU_SLL;
      F3_SLT:     op = ALU_SLT;
      F3_SLTU:    op = ALU_SLTU;
      F3_XOR:     op = ALU_XOR;
      F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:      op = ALU_OR;
      default:    op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/id_ex_decode_if.sv
// ID -> EX decode bundle. master drives the instruction side, slave is the
// decode/pipeline register that produces the EX-stage entry.
interface id_ex_decode_if;
  logic        stall;
  logic        flush;
  logic        inst_valid_in;
  logic [31:0] inst_in;
  logic [31:0] pc_in;

  logic        valid_out;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic [3:0]  alu_ctr;
  logic        a_sel;
  logic        b_sel;
  logic [31:0] imm;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        reg_wen;
  logic        mem_ren;
  logic        mem_wen;
  logic        br;
  logic        jmp;
  logic        csr_wen;
  logic        illegal;

  modport master (
    output stall, flush, inst_valid_in, inst_in, pc_in,
    input  valid_out, inst_out, pc_out, alu_ctr, a_sel, b_sel, imm,
           rs1, rs2, rd, reg_wen, mem_ren, mem_wen, br, jmp, csr_wen, illegal
  );

  modport slave (
    input  stall, flush, inst_valid_in, inst_in, pc_in,
    output valid_out, inst_out, pc_out, alu_ctr, a_sel, b_sel, imm,
           rs1, rs2, rd, reg_wen, mem_ren, mem_wen, br, jmp, csr_wen, illegal
  );
endinterface

// File: rtl/imm_gen.sv
// RV32I immediate generator: selects I/S/B/U/J format from the opcode.
// Shift-immediates carry only the shamt; CSR immediate forms carry zimm.
module imm_gen
  import id_ex_decode_pkg::*;
(
  input  logic [31:0] inst,
  output logic [31:0] imm
);

  logic [6:0] opcode;
  logic [2:0] funct3;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];

  // Format select by opcode
  always_comb begin
    imm = '0;
    case (opcode)
      OPC_OP_IMM: begin
        if (funct3 == F3_SLL || funct3 == F3_SRL_SRA)
          imm = {27'd0, inst[24:20]};
        else
          imm = {{20{inst[31]}}, inst[31:20]};
      end
      OPC_LOAD, OPC_JALR:
        imm = {{20{inst[31]}}, inst[31:20]};
      OPC_STORE:
        imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OPC_BRANCH:
        imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm = {inst[31:12], 12'd0};
      OPC_JAL:
        imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      OPC_SYSTEM: begin
        if (funct3[2])
          imm = {27'd0, inst[19:15]};
        else
          imm = {{20{inst[31]}}, inst[31:20]};
      end
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/id_ex_decode.sv
// ID/EX decode stage: combinational RV32I decode of inst_in, registered into
// a single EX-stage entry with 1-cycle latency.
// Edge priority: rst > flush > stall > load.
module id_ex_decode
  import id_ex_decode_pkg::*;
#(
  parameter logic [31:0] NOP_INST = 32'h0000_0013
)(
  input logic         clk,
  input logic         rst,
  id_ex_decode_if.slave bus
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_w;
  ex_entry_t   dec;
  ex_entry_t   entry;

  assign opcode = bus.inst_in[6:0];
  assign funct3 = bus.inst_in[14:12];
  assign funct7 = bus.inst_in[31:25];

  imm_gen u_imm_gen (
    .inst (bus.inst_in),
    .imm  (imm_w)
  );

  // Decode the incoming instruction into a candidate entry
  always_comb begin
    dec         = '0;
    dec.valid   = 1'b1;
    dec.inst    = bus.inst_in;
    dec.pc      = bus.pc_in;
    dec.imm     = imm_w;
    dec.rs1     = bus.inst_in[19:15];
    dec.rs2     = bus.inst_in[24:20];
    dec.rd      = bus.inst_in[11:7];
    case (opcode)
      OPC_OP: begin
        dec.alu_ctr = alu_from_funct3(funct3, funct7[5]);
        dec.reg_wen = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.b_sel   = 1'b1;
        dec.reg_wen = 1'b1;
        if (funct3 == F3_SLL) begin
          dec.alu_ctr = ALU_SLL;
          dec.illegal = (funct7 != F7_BASE);
        end else if (funct3 == F3_SRL_SRA) begin
          if (funct7 == F7_BASE)     dec.alu_ctr = ALU_SRL;
          else if (funct7 == F7_ALT) dec.alu_ctr = ALU_SRA;
          else                       dec.illegal = 1'b1;
        end else begin
          dec.alu_ctr = alu_from_funct3(funct3, 1'b0);
        end
      end
      OPC_LUI: begin
        dec.alu_ctr = ALU_PASS_B;
        dec.b_sel   = 1'b1;
        dec.reg_wen = 1'b1;
      end
      OPC_AUIPC: begin
        dec.alu_ctr = ALU_ADD;
        dec.a_sel   = 1'b1;
        dec.b_sel   = 1'b1;
        dec.reg_wen = 1'b1;
      end
      OPC_JAL: begin
        dec.alu_ctr = ALU_ADD;
        dec.a_sel   = 1'b1;
        dec.b_sel   = 1'b1;
        dec.jmp     = 1'b1;
        dec.reg_wen = 1'b1;
      end
      OPC_JALR: begin
        dec.alu_ctr = ALU_ADD;
        dec.b_sel   = 1'b1;
        dec.jmp     = 1'b1;
        dec.reg_wen = 1'b1;
      end
      OPC_BRANCH: begin
        dec.alu_ctr = ALU_ADD;
        dec.a_sel   = 1'b1;
        dec.b_sel   = 1'b1;
        dec.br      = 1'b1;
      end
      OPC_LOAD: begin
        dec.alu_ctr = ALU_ADD;
        dec.b_sel   = 1'b1;
        dec.mem_ren = 1'b1;
        dec.reg_wen = 1'b1;
      end
      OPC_STORE: begin
        dec.alu_ctr = ALU_ADD;
        dec.b_sel   = 1'b1;
        dec.mem_wen = 1'b1;
      end
      OPC_SYSTEM: begin
        if (funct3 == F3_CSRRW) begin
          dec.alu_ctr = ALU_PASS_A;
          dec.csr_wen = 1'b1;
          dec.reg_wen = 1'b1;
        end else if (funct3 == F3_CSRRWI) begin
          dec.alu_ctr = ALU_PASS_B;
          dec.b_sel   = 1'b1;
          dec.csr_wen = 1'b1;
          dec.reg_wen = 1'b1;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      default: dec.illegal = 1'b1;
    endcase

    // Illegal encodings keep the entry valid but strip every side effect
    if (dec.illegal) begin
      dec.alu_ctr = ALU_ADD;
      dec.a_sel   = 1'b0;
      dec.b_sel   = 1'b0;
      dec.reg_wen = 1'b0;
      dec.mem_ren = 1'b0;
      dec.mem_wen = 1'b0;
      dec.br      = 1'b0;
      dec.jmp     = 1'b0;
      dec.csr_wen = 1'b0;
    end

    // Writes to x0 are never architecturally visible
    if (dec.rd == 5'd0)
      dec.reg_wen = 1'b0;
  end

  // Pipeline register: reset/flush insert a bubble, stall holds, otherwise load
  always_ff @(posedge clk) begin
    if (rst)
      entry <= bubble_entry(NOP_INST);
    else if (bus.flush)
      entry <= bubble_entry(NOP_INST);
    else if (!bus.stall) begin
      if (bus.inst_valid_in) entry <= dec;
      else                   entry <= bubble_entry(NOP_INST);
    end
  end

  assign bus.valid_out = entry.valid;
  assign bus.inst_out  = entry.inst;
  assign bus.pc_out    = entry.pc;
  assign bus.alu_ctr   = entry.alu_ctr;
  assign bus.a_sel     = entry.a_sel;
  assign bus.b_sel     = entry.b_sel;
  assign bus.imm       = entry.imm;
  assign bus.rs1       = entry.rs1;
  assign bus.rs2       = entry.rs2;
  assign bus.rd        = entry.rd;
  assign bus.reg_wen   = entry.reg_wen;
  assign bus.mem_ren   = entry.mem_ren;
  assign bus.mem_wen   = entry.mem_wen;
  assign bus.br        = entry.br;
  assign bus.jmp       = entry.jmp;
  assign bus.csr_wen   = entry.csr_wen;
  assign bus.illegal   = entry.illegal;

endmodule

// File: tb/tb_id_ex_decode.sv
// Directed table-driven bench for id_ex_decode plus hand sequences for
// reset, stall hold and flush-over-stall.
module tb_id_ex_decode;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  int unsigned checks   = 0;
  int unsigned failures = 0;

  id_ex_decode_if bus();

  id_ex_decode #(.NOP_INST(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // flags order: {reg_wen, mem_ren, mem_wen, br, jmp, csr_wen, illegal}
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        vld;
    logic [3:0]  alu;
    logic        asel;
    logic        bsel;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  fl;
  } vec_t;

  localparam int unsigned NVEC = 18;
  vec_t vecs [NVEC];

  function automatic logic [6:0] dut_flags();
    return {bus.reg_wen, bus.mem_ren, bus.mem_wen, bus.br, bus.jmp, bus.csr_wen, bus.illegal};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic st, input logic fl);
    bus.inst_valid_in = v;
    bus.inst_in       = inst;
    bus.pc_in         = pc;
    bus.stall         = st;
    bus.flush         = fl;
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, ".valid"}, {31'd0, bus.valid_out}, 32'd0);
    chk({tag, ".inst"},  bus.inst_out, NOP);
    chk({tag, ".pc"},    bus.pc_out, 32'd0);
    chk({tag, ".alu"},   {28'd0, bus.alu_ctr}, 32'd0);
    chk({tag, ".rd"},    {27'd0, bus.rd}, 32'd0);
    chk({tag, ".flags"}, {25'd0, dut_flags()}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{32'h40B50533, 32'h100, 1'b1, 4'd1,  1'b0, 1'b0, 32'h0,        5'd10, 5'd10, 5'd11, 7'b1000000}; // sub a0,a0,a1
    vecs[1]  = '{32'h4030D093, 32'h104, 1'b1, 4'd9,  1'b0, 1'b1, 32'd3,        5'd1,  5'd1,  5'd3,  7'b1000000}; // srai x1,x1,3
    vecs[2]  = '{32'hFFF00093, 32'h108, 1'b1, 4'd0,  1'b0, 1'b1, 32'hFFFFFFFF, 5'd1,  5'd0,  5'd31, 7'b1000000}; // addi x1,x0,-1
    vecs[3]  = '{32'hFE512E23, 32'h10C, 1'b1, 4'd0,  1'b0, 1'b1, 32'hFFFFFFFC, 5'd28, 5'd2,  5'd5,  7'b0010000}; // sw x5,-4(x2)
    vecs[4]  = '{32'h0000007F, 32'h110, 1'b1, 4'd0,  1'b0, 1'b0, 32'h0,        5'd0,  5'd0,  5'd0,  7'b0000001}; // bad opcode
    vecs[5]  = '{32'h800002B7, 32'h114, 1'b1, 4'd12, 1'b0, 1'b1, 32'h80000000, 5'd5,  5'd0,  5'd0,  7'b1000000}; // lui x5,0x80000
    vecs[6]  = '{32'h00001197, 32'h118, 1'b1, 4'd0,  1'b1, 1'b1, 32'h00001000, 5'd3,  5'd0,  5'd0,  7'b1000000}; // auipc x3,1
    vecs[7]  = '{32'hFF9FF0EF, 32'h11C, 1'b1, 4'd0,  1'b1, 1'b1, 32'hFFFFFFF8, 5'd1,  5'd31, 5'd25, 7'b1000100}; // jal ra,-8
    vecs[8]  = '{32'h00108067, 32'h120, 1'b1, 4'd0,  1'b0, 1'b1, 32'h1,        5'd0,  5'd1,  5'd1,  7'b0000100}; // jalr x0,1(x1)
    vecs[9]  = '{32'h00208463, 32'h124, 1'b1, 4'd0,  1'b1, 1'b1, 32'h8,        5'd8,  5'd1,  5'd2,  7'b0001000}; // beq x1,x2,+8
    vecs[10] = '{32'h00C3A303, 32'h128, 1'b1, 4'd0,  1'b0, 1'b1, 32'd12,       5'd6,  5'd7,  5'd12, 7'b1100000}; // lw x6,12(x7)
    vecs[11] = '{32'h300312F3, 32'h12C, 1'b1, 4'd11, 1'b0, 1'b0, 32'h300,      5'd5,  5'd6,  5'd0,  7'b1000010}; // csrrw x5,0x300,x6
    vecs[12] = '{32'h3052D073, 32'h130, 1'b1, 4'd12, 1'b0, 1'b1, 32'd5,        5'd0,  5'd5,  5'd5,  7'b0000010}; // csrrwi x0,0x305,5
    vecs[13] = '{32'h40109093, 32'h134, 1'b1, 4'd0,  1'b0, 1'b0, 32'd1,        5'd1,  5'd1,  5'd1,  7'b0000001}; // slli, bad funct7
    vecs[14] = '{32'h30002073, 32'h138, 1'b1, 4'd0,  1'b0, 1'b0, 32'h300,      5'd0,  5'd0,  5'd0,  7'b0000001}; // csrrs -> illegal
    vecs[15] = '{32'h40B50533, 32'h13C, 1'b0, 4'd0,  1'b0, 1'b0, 32'h0,        5'd0,  5'd0,  5'd0,  7'b0000000}; // not valid -> bubble
    vecs[16] = '{32'h405251B3, 32'h140, 1'b1, 4'd9,  1'b0, 1'b0, 32'h0,        5'd3,  5'd4,  5'd5,  7'b1000000}; // sra x3,x4,x5
    vecs[17] = '{32'h00208033, 32'h144, 1'b1, 4'd0,  1'b0, 1'b0, 32'h0,        5'd0,  5'd1,  5'd2,  7'b0000000}; // add x0,x1,x2

    // Reset state
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    step();
    chk_bubble("reset");
    rst = 1'b0;

    // Table of single-instruction vectors
    for (int unsigned i = 0; i < NVEC; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      drive(vecs[i].vld, vecs[i].inst, vecs[i].pc, 1'b0, 1'b0);
      step();
      chk({t, ".valid"}, {31'd0, bus.valid_out}, {31'd0, vecs[i].vld});
      chk({t, ".inst"},  bus.inst_out, vecs[i].vld ? vecs[i].inst : NOP);
      chk({t, ".pc"},    bus.pc_out,   vecs[i].vld ? vecs[i].pc : 32'd0);
      chk({t, ".alu"},   {28'd0, bus.alu_ctr}, {28'd0, vecs[i].alu});
      chk({t, ".asel"},  {31'd0, bus.a_sel}, {31'd0, vecs[i].asel});
      chk({t, ".bsel"},  {31'd0, bus.b_sel}, {31'd0, vecs[i].bsel});
      chk({t, ".imm"},   bus.imm, vecs[i].imm);
      chk({t, ".rd"},    {27'd0, bus.rd},  {27'd0, vecs[i].rd});
      chk({t, ".rs1"},   {27'd0, bus.rs1}, {27'd0, vecs[i].rs1});
      chk({t, ".rs2"},   {27'd0, bus.rs2}, {27'd0, vecs[i].rs2});
      chk({t, ".flags"}, {25'd0, dut_flags()}, {25'd0, vecs[i].fl});
    end

    // Stall hold: sw loaded, then 3 stalled cycles with a different inst_in
    drive(1'b1, 32'hFE512E23, 32'h200, 1'b0, 1'b0);
    step();
    chk("stall.load.memwen", {31'd0, bus.mem_wen}, 32'd1);
    for (int unsigned c = 0; c < 3; c++) begin
      string t;
      t = $sformatf("stall%0d", c);
      drive(1'b1, 32'h40B50533, 32'h300 + c, 1'b1, 1'b0);
      step();
      chk({t, ".valid"},  {31'd0, bus.valid_out}, 32'd1);
      chk({t, ".inst"},   bus.inst_out, 32'hFE512E23);
      chk({t, ".pc"},     bus.pc_out, 32'h200);
      chk({t, ".memwen"}, {31'd0, bus.mem_wen}, 32'd1);
      chk({t, ".imm"},    bus.imm, 32'hFFFFFFFC);
      chk({t, ".alu"},    {28'd0, bus.alu_ctr}, 32'd0);
    end
    drive(1'b1, 32'h40B50533, 32'h310, 1'b0, 1'b0);
    step();
    chk("unstall.inst", bus.inst_out, 32'h40B50533);
    chk("unstall.alu",  {28'd0, bus.alu_ctr}, 32'd1);

    // Flush beats stall while a valid beq is presented
    drive(1'b1, 32'h00208463, 32'h400, 1'b0, 1'b0);
    step();
    chk("flush.pre.br", {31'd0, bus.br}, 32'd1);
    drive(1'b1, 32'h00208463, 32'h404, 1'b1, 1'b1);
    step();
    chk("flush.valid", {31'd0, bus.valid_out}, 32'd0);
    chk("flush.br",    {31'd0, bus.br}, 32'd0);
    chk_bubble("flush_stall");

    // Flush alone with a valid lui
    drive(1'b1, 32'h800002B7, 32'h408, 1'b0, 1'b1);
    step();
    chk_bubble("flush_only");

    // Reset beats stall with a valid entry held
    drive(1'b1, 32'h40B50533, 32'h500, 1'b0, 1'b0);
    step();
    chk("rst.pre.valid", {31'd0, bus.valid_out}, 32'd1);
    rst = 1'b1;
    drive(1'b1, 32'h40B50533, 32'h504, 1'b1, 1'b0);
    step();
    chk_bubble("rst_stall");
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
